// File: rtl/mux_2to1_32.sv
// Two-input word selector for CPU datapath operand and write-back paths.
// Combinational result on o, plus an optional enabled, flopped copy with a valid flag.
module mux_2to1_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q_valid
);

    // NOTE: every path assigns o, so no latch can be inferred; keep it that way if this grows.
    always_comb begin
        o = sel ? b : a;
    end

    // Reset wins over en so a mid-stream flush always clears the stage boundary.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q       <= '0;
            o_q_valid <= 1'b0;
        end else if (en) begin
            o_q       <= o;
            o_q_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_2to1_32.sv
// Self-checking bench for mux_2to1_32: directed cases followed by randomized cycles
// compared against a word-table reference model.
module tb_mux_2to1_32;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             en;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] o_q;
    logic             o_q_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state for the registered stage
    logic [WIDTH-1:0] exp_q;
    logic             exp_v;

    mux_2to1_32 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .en        (en),
        .o         (o),
        .o_q       (o_q),
        .o_q_valid (o_q_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Selection expressed as a lookup into the pair of candidate words
    function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] wa, input logic [WIDTH-1:0] wb,
                                              input logic s);
        logic [WIDTH-1:0] words [2];
        words[0] = wa;
        words[1] = wb;
        return words[s];
    endfunction

    initial begin
        logic [WIDTH-1:0] one;

        rst = 1'b1; en = 1'b0; sel = 1'b0; a = '0; b = '0;
        #100;
        check("all_zero_o", o, 32'h0000_0000);

        tick();
        check("reset_o_q", o_q, '0);
        check("reset_valid", {31'b0, o_q_valid}, 32'd0);
        rst = 1'b0;

        a = 32'hDEAD_BEEF; b = 32'h1234_5678; sel = 1'b0;
        #1 check("sel_a", o, 32'hDEAD_BEEF);
        sel = 1'b1;
        #1 check("sel_b", o, 32'h1234_5678);

        a = 32'hFFFF_FFFF; b = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            sel = i[0];
            #1 check("toggle", o, i[0] ? 32'h0000_0000 : 32'hFFFF_FFFF);
        end

        sel = 1'b1;
        one = 32'd1;
        for (int i = 0; i < WIDTH; i++) begin
            b = one << i;
            #1 check("walk_one", o, one << i);
        end
        check("idle_valid", {31'b0, o_q_valid}, 32'd0);

        tick();
        en = 1'b1; sel = 1'b1; b = 32'hCAFE_F00D;
        tick();
        check("load_o_q", o_q, 32'hCAFE_F00D);
        check("load_valid", {31'b0, o_q_valid}, 32'd1);
        en = 1'b0; b = 32'h5555_AAAA;
        tick();
        check("hold_o_q", o_q, 32'hCAFE_F00D);
        check("hold_valid", {31'b0, o_q_valid}, 32'd1);

        rst = 1'b1; en = 1'b1; a = 32'h0000_0001; sel = 1'b0;
        #1 check("rst_prio_o_pre", o, 32'h0000_0001);
        tick();
        check("rst_prio_o_q", o_q, '0);
        check("rst_prio_valid", {31'b0, o_q_valid}, 32'd0);
        check("rst_prio_o_post", o, 32'h0000_0001);
        rst = 1'b0; en = 1'b0;

        exp_q = '0;
        exp_v = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            a   = $urandom;
            b   = $urandom;
            sel = 1'($urandom_range(0, 1));
            en  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 31) == 0);
            #1 check("rand_o", o, pick(a, b, sel));
            if (rst) begin
                exp_q = '0;
                exp_v = 1'b0;
            end else if (en) begin
                exp_q = pick(a, b, sel);
                exp_v = 1'b1;
            end
            tick();
            check("rand_o_q", o_q, exp_q);
            check("rand_valid", {31'b0, o_q_valid}, {31'b0, exp_v});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_2to1_32.md
# mux_2to1_32

Two-input, 32-bit-wide word selector used on CPU datapath operand and write-back paths (e.g. ALU source, register write-data). Drives a combinational output `o` that selects input `a` or `b` under `sel`. Also provides a registered copy of the selected word, with enable and valid flag, for stage boundaries that need a flopped mux result. The combinational path is the primary function; the registered path is optional for users and may be left unconnected.

## Interface
- `WIDTH`, default 32: data width of `a`, `b`, `o`, `o_q`.
- `clk`  input  1  single clock; all flops rising-edge.
- `rst`  input  1  reset, synchronous, active-high.
- `a`  input  WIDTH  data selected when `sel`=0.
- `b`  input  WIDTH  data selected when `sel`=1.
- `sel`  input  1  select: 0 -> `a`, 1 -> `b`.
- `en`  input  1  load enable for registered stage.
- `o`  output  WIDTH  combinational selected word.
- `o_q`  output  WIDTH  registered selected word.
- `o_q_valid`  output  1  high once `o_q` holds a loaded value since reset.

## Operation
- Combinational: `o` = `sel` ? `b` : `a`, bitwise over the full WIDTH.
  - No clock or reset dependency.
  - Valid while `clk` is stopped and while `rst` is asserted.
- `o` responds to any change of `a`, `b` or `sel` in the same delta/cycle. No latches.
- Registered stage, evaluated on the rising edge of `clk`:
  - `rst`=1: `o_q` <= 0, `o_q_valid` <= 0. Reset has priority over `en`.
  - `rst`=0, `en`=1: `o_q` <= current `o`; `o_q_valid` <= 1.
  - `rst`=0, `en`=0: `o_q` and `o_q_valid` hold.
- `o_q_valid` stays 1 after the first load until the next reset.
- No arithmetic and no width conversion. Inputs and outputs are exactly WIDTH bits. No sign or zero extension.
- `sel` driven X/Z: `o` is not required to be defined; `o_q` loaded under such a `sel` is likewise undefined.

## Timing
- `o`: zero-cycle latency (pure combinational path `a`/`b`/`sel` -> `o`).
- `o_q`: one-cycle latency. It reflects the `a`/`b`/`sel` values sampled at the rising edge where `en`=1.
- Reset values: `o_q`=0 and `o_q_valid`=0, effective at the first rising edge with `rst`=1. Before that edge both are unknown.
- Reset mid-operation: the registered stage clears at the next edge regardless of `en`. `o` is unaffected.
- `sel` toggling in the same cycle as `en`=1: the value of `sel` at the edge decides what is loaded.
- No handshake; `en` is a plain qualifier with no back-pressure.

## Test plan
- All zero: `a`=0, `b`=0, `sel`=0 held 100 ns -> `o`=0x00000000.
- Select a/b:
  - `a`=0xDEADBEEF, `b`=0x12345678, `sel`=0 -> `o`=0xDEADBEEF.
  - Then `sel`=1 -> `o`=0x12345678 with no clock edge.
- Full-width bit isolation: `a`=0xFFFFFFFF, `b`=0x00000000.
  - Toggle `sel` -> `o` alternates 0xFFFFFFFF / 0x00000000.
  - Walking-one on `b` with `sel`=1 -> `o` matches bit-for-bit across all 32 positions.
- Registered path:
  - After reset (`rst`=1 for one edge) -> `o_q`=0, `o_q_valid`=0.
  - `en`=1, `sel`=1, `b`=0xCAFEF00D at an edge -> `o_q`=0xCAFEF00D and `o_q_valid`=1 after that edge.
  - `en`=0, change `b` -> `o_q` holds.
- Reset priority: `rst`=1 and `en`=1 on the same edge with `a`=0x1 and `sel`=0 -> `o_q`=0, `o_q_valid`=0. Meanwhile `o`=0x00000001 throughout.
- Random: 1000 random `a`/`b`/`sel`/`en` cycles checked against a reference model of `o` and a one-cycle-delayed model of `o_q`.
